// File: rtl/stage_mem_pkg.sv
// Shared pipeline definitions: MEM-stage FSM state encodings, ALU opcodes and small decode helpers.
// Imported by the MEM stage and its control FSM.
package stage_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8
  } alu_op_e;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/stage_mem_fsm.sv
// MEM-stage control: accepts in IDLE, waits in WAIT for mem_ack; completion is visible one edge after accept/ack.
// Stall and mem_req are pure decodes of the registered state, so upstream holds for exactly the WAIT cycles.
module stage_mem_fsm
  import stage_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic flush,
  input  logic mem_op,
  input  logic misaligned,
  input  logic mem_ack,
  output logic accept_direct,
  output logic accept_mem,
  output logic complete_mem,
  output logic stall,
  output logic mem_req
);

  mem_state_e state, state_nxt;
  logic       accept;

  assign accept = valid & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && mem_op && !misaligned) state_nxt = WAIT;
      WAIT: if (mem_ack) state_nxt = IDLE;
    endcase
  end

  // An access already in WAIT predates any flush, so ack is the only way out.
  always_comb begin
    accept_direct = 1'b0;
    accept_mem    = 1'b0;
    complete_mem  = 1'b0;
    stall         = 1'b0;
    mem_req       = 1'b0;
    case (state)
      IDLE: begin
        accept_direct = accept & (~mem_op | misaligned);
        accept_mem    = accept & mem_op & ~misaligned;
      end
      WAIT: begin
        complete_mem = mem_ack;
        stall        = 1'b1;
        mem_req      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: non-memory ops 1 cycle, memory ops 1 + ack-wait cycles; Stall holds upstream while an access is in flight.
// Optional MEM_ALIGN_CHECK_EN turns word-misaligned accesses into immediate, request-free completions.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          BeginStageMEM_Valid,
  input  logic          CS_MemRead,
  input  logic          CS_MemWrite,
  input  logic          Flush,
  input  logic [DW-1:0] BeginStageMEM_Inst,
  input  logic [DW-1:0] BeginStageMEM_NewPC,
  input  logic [DW-1:0] BeginStageMEM_RegDataB,
  input  logic [DW-1:0] BeginStageMEM_ALUOutput,
  input  logic          BeginStageMEM_Condition,
  output logic          Stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          EndStageMEM_Valid,
  output logic [DW-1:0] EndStageMEM_Inst,
  output logic [DW-1:0] EndStageMEM_NewPC,
  output logic [DW-1:0] EndStageMEM_ALUOutput,
  output logic [DW-1:0] EndStageMEM_MemData,
  output logic          EndStageMEM_Condition,
  output logic          EndStageMEM_Misaligned
);

  logic          mem_op;
  logic          misaligned;
  logic          accept_direct;
  logic          accept_mem;
  logic          complete_mem;
  logic          hold_we;
  logic          hold_cond;
  logic [DW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [DW-1:0] hold_inst;
  logic [DW-1:0] hold_newpc;

  assign mem_op = is_mem_op(CS_MemRead, CS_MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (|BeginStageMEM_ALUOutput[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  stage_mem_fsm u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid         (BeginStageMEM_Valid),
    .flush         (Flush),
    .mem_op        (mem_op),
    .misaligned    (misaligned),
    .mem_ack       (mem_ack),
    .accept_direct (accept_direct),
    .accept_mem    (accept_mem),
    .complete_mem  (complete_mem),
    .stall         (Stall),
    .mem_req       (mem_req)
  );

  // Effective address doubles as the ALU result passed to write-back.
  assign mem_we    = mem_req & hold_we;
  assign mem_addr  = hold_addr;
  assign mem_wdata = hold_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we    <= 1'b0;
      hold_cond  <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_inst  <= '0;
      hold_newpc <= '0;
    end else if (accept_mem) begin
      hold_we    <= CS_MemWrite;
      hold_cond  <= BeginStageMEM_Condition;
      hold_addr  <= BeginStageMEM_ALUOutput;
      hold_wdata <= BeginStageMEM_RegDataB;
      hold_inst  <= BeginStageMEM_Inst;
      hold_newpc <= BeginStageMEM_NewPC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EndStageMEM_Valid     <= 1'b0;
      EndStageMEM_Inst      <= '0;
      EndStageMEM_NewPC     <= '0;
      EndStageMEM_ALUOutput <= '0;
      EndStageMEM_MemData   <= '0;
      EndStageMEM_Condition <= 1'b0;
    end else begin
      EndStageMEM_Valid <= accept_direct | complete_mem;
      if (accept_direct) begin
        EndStageMEM_Inst      <= BeginStageMEM_Inst;
        EndStageMEM_NewPC     <= BeginStageMEM_NewPC;
        EndStageMEM_ALUOutput <= BeginStageMEM_ALUOutput;
        EndStageMEM_MemData   <= '0;
        EndStageMEM_Condition <= BeginStageMEM_Condition;
      end else if (complete_mem) begin
        EndStageMEM_Inst      <= hold_inst;
        EndStageMEM_NewPC     <= hold_newpc;
        EndStageMEM_ALUOutput <= hold_addr;
        EndStageMEM_MemData   <= hold_we ? '0 : mem_rdata;
        EndStageMEM_Condition <= hold_cond;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (accept_direct) begin
      mis_q <= misaligned;
    end else if (complete_mem) begin
      mis_q <= 1'b0;
    end
  end

  assign EndStageMEM_Misaligned = mis_q;
`else
  assign EndStageMEM_Misaligned = 1'b0;
`endif

endmodule
